// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-enabled synchronous data RAM plus the EX/MEM -> MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int ADDR_W = 10,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WB_W-1:0]   wbi,
  input  logic [4:0]        regaddr,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       data,
  input  logic [31:0]       dataaddr,
  input  logic              forw,
  input  logic [31:0]       result_from_mem,
  output logic [WB_W-1:0]   wbo,
  output logic [31:0]       datafrommem,
  output logic [31:0]       datafromimm,
  output logic [4:0]        regaddrout,
  output logic              misalign
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       store_data;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              is_byte;
  logic              is_half;
  logic [3:0]        byte_en;
  logic [3:0][7:0]   lane_wdata;
  logic              wr_block;
  logic              wr_en;

  logic [31:0]       rd_word_reg;
  logic [WB_W-1:0]   wbo_reg;
  logic [31:0]       imm_reg;
  logic [4:0]        regaddr_reg;
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic              sext_reg;
  logic              re_reg;
  logic              misalign_q;

  assign store_data = forw ? result_from_mem : data;
  assign word_idx   = dataaddr[ADDR_W+1:2];
  assign byte_off   = dataaddr[1:0];
  assign is_byte    = (size == 2'b00);
  assign is_half    = (size == 2'b01);

  // Without the trap, ignoring the low offset bits naturally truncates to alignment.
  always_comb begin
    byte_en = 4'b1111;
    if (is_byte)
      byte_en = 4'b0001 << byte_off;
    else if (is_half)
      byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
  end

  // Narrow stores are replicated across lanes; byte_en picks the live ones.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[gi] = is_byte ? store_data[7:0] :
                              is_half ? store_data[8*(gi%2) +: 8] :
                                        store_data[8*gi +: 8];
    end
  endgenerate

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misaligned_next;
  logic misalign_reg;

  assign misaligned_next = (is_half && byte_off[0]) ||
                           (!is_byte && !is_half && (byte_off != 2'b00));
  assign wr_block = misaligned_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_reg <= 1'b0;
    else
      misalign_reg <= misaligned_next && (mem_we || mem_re);
  end
  assign misalign_q = misalign_reg;
`else
  assign wr_block   = 1'b0;
  assign misalign_q = 1'b0;
`endif

  // reset gates the write so an edge during reset cannot corrupt memory contents.
  assign wr_en = mem_we && !reset && !wr_block;

  // Read-first RAM: the registered read sees the pre-write word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && byte_en[i])
        mem[word_idx][i*8 +: 8] <= lane_wdata[i];
    end
    rd_word_reg <= mem[word_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbo_reg     <= '0;
      imm_reg     <= '0;
      regaddr_reg <= '0;
      off_reg     <= '0;
      size_reg    <= '0;
      sext_reg    <= 1'b0;
      re_reg      <= 1'b0;
    end else begin
      wbo_reg     <= wbi;
      imm_reg     <= dataaddr;
      regaddr_reg <= regaddr;
      off_reg     <= byte_off;
      size_reg    <= size;
      sext_reg    <= sign_ext;
      re_reg      <= mem_re;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte     = rd_word_reg[8*off_reg +: 8];
    ld_half     = off_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    datafrommem = 32'h0;
    if (re_reg && !misalign_q) begin
      case (size_reg)
        2'b00:   datafrommem = {{24{sext_reg & ld_byte[7]}}, ld_byte};
        2'b01:   datafrommem = {{16{sext_reg & ld_half[15]}}, ld_half};
        default: datafrommem = rd_word_reg;
      endcase
    end
  end

  assign wbo         = wbo_reg;
  assign datafromimm = imm_reg;
  assign regaddrout  = regaddr_reg;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations follow MEM_STAGE_MISALIGN_TRAP_EN if defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wbi;
  logic [4:0]  regaddr;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] data;
  logic [31:0] dataaddr;
  logic        forw;
  logic [31:0] result_from_mem;
  logic [1:0]  wbo;
  logic [31:0] datafrommem;
  logic [31:0] datafromimm;
  logic [4:0]  regaddrout;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(10), .WB_W(2)) dut (
    .clk(clk), .reset(reset), .wbi(wbi), .regaddr(regaddr),
    .mem_we(mem_we), .mem_re(mem_re), .size(size), .sign_ext(sign_ext),
    .data(data), .dataaddr(dataaddr), .forw(forw),
    .result_from_mem(result_from_mem), .wbo(wbo), .datafrommem(datafrommem),
    .datafromimm(datafromimm), .regaddrout(regaddrout), .misalign(misalign)
  );

  // Presents one instruction at the falling edge, lets it through one rising edge,
  // and returns with its outputs settled (#1 after the edge).
  task automatic op(input logic we, input logic re, input logic [1:0] sz, input logic sx,
                    input logic [31:0] d, input logic [31:0] a, input logic fw,
                    input logic [31:0] rfm, input logic [1:0] wb, input logic [4:0] rd);
    @(negedge clk);
    mem_we = we; mem_re = re; size = sz; sign_ext = sx; data = d; dataaddr = a;
    forw = fw; result_from_mem = rfm; wbi = wb; regaddr = rd;
    @(posedge clk);
    #1;
    $display("op we=%0b re=%0b size=%0d addr=0x%08h -> dout=0x%08h wbo=%0d rd=%0d mis=%0b",
             we, re, sz, a, datafrommem, wbo, regaddrout, misalign);
  endtask

  task automatic idle_inputs();
    mem_we = 0; mem_re = 0; size = 2'b10; sign_ext = 0; data = 0; dataaddr = 0;
    forw = 0; result_from_mem = 0; wbi = 0; regaddr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wbi = 2'b11; regaddr = 5'd7; dataaddr = 32'h1234; mem_re = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wbo !== 2'b00) begin errors++; $display("FAIL reset_wbo got=%0h exp=0", wbo); end
    checks++; if (datafromimm !== 32'h0) begin errors++; $display("FAIL reset_imm got=%08h exp=0", datafromimm); end
    checks++; if (regaddrout !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", regaddrout); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got=%0b exp=0", misalign); end
    checks++; if (datafrommem !== 32'h0) begin errors++; $display("FAIL reset_dout got=%08h exp=0", datafrommem); end
    @(negedge clk);
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_word();
    op(1, 0, 2'b10, 0, 32'h11223344, 32'h10, 0, 0, 2'b10, 5'd3);
    checks++; if (datafromimm !== 32'h10) begin errors++; $display("FAIL sw_imm got=%08h exp=00000010", datafromimm); end
    checks++; if (wbo !== 2'b10) begin errors++; $display("FAIL sw_wbo got=%0h exp=2", wbo); end
    checks++; if (regaddrout !== 5'd3) begin errors++; $display("FAIL sw_rd got=%0d exp=3", regaddrout); end
    checks++; if (datafrommem !== 32'h0) begin errors++; $display("FAIL sw_dout_nore got=%08h exp=0", datafrommem); end
    op(0, 1, 2'b10, 0, 0, 32'h10, 0, 0, 2'b01, 5'd9);
    checks++; if (datafrommem !== 32'h11223344) begin errors++; $display("FAIL lw got=%08h exp=11223344", datafrommem); end
    checks++; if (regaddrout !== 5'd9) begin errors++; $display("FAIL lw_rd got=%0d exp=9", regaddrout); end
    op(0, 1, 2'b11, 0, 0, 32'h10, 0, 0, 2'b01, 5'd9);
    checks++; if (datafrommem !== 32'h11223344) begin errors++; $display("FAIL lw_size3 got=%08h exp=11223344", datafrommem); end
  endtask

  task automatic test_byte();
    op(1, 0, 2'b00, 0, 32'h000000AA, 32'h13, 0, 0, 2'b00, 5'd0);
    op(0, 1, 2'b10, 0, 0, 32'h10, 0, 0, 2'b01, 5'd1);
    checks++; if (datafrommem !== 32'hAA223344) begin errors++; $display("FAIL sb_lw got=%08h exp=AA223344", datafrommem); end
    op(0, 1, 2'b00, 1, 0, 32'h13, 0, 0, 2'b01, 5'd1);
    checks++; if (datafrommem !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb got=%08h exp=FFFFFFAA", datafrommem); end
    op(0, 1, 2'b00, 0, 0, 32'h13, 0, 0, 2'b01, 5'd1);
    checks++; if (datafrommem !== 32'h000000AA) begin errors++; $display("FAIL lbu got=%08h exp=000000AA", datafrommem); end
    op(0, 1, 2'b00, 1, 0, 32'h11, 0, 0, 2'b01, 5'd1);
    checks++; if (datafrommem !== 32'h00000033) begin errors++; $display("FAIL lb_lane1 got=%08h exp=00000033", datafrommem); end
  endtask

  task automatic test_half();
    op(1, 0, 2'b10, 0, 32'h0, 32'h20, 0, 0, 2'b00, 5'd0);
    op(1, 0, 2'b01, 0, 32'h0, 32'h22, 1, 32'h00008001, 2'b00, 5'd0);
    op(0, 1, 2'b01, 1, 0, 32'h22, 0, 0, 2'b01, 5'd2);
    checks++; if (datafrommem !== 32'hFFFF8001) begin errors++; $display("FAIL lh got=%08h exp=FFFF8001", datafrommem); end
    op(0, 1, 2'b01, 0, 0, 32'h22, 0, 0, 2'b01, 5'd2);
    checks++; if (datafrommem !== 32'h00008001) begin errors++; $display("FAIL lhu got=%08h exp=00008001", datafrommem); end
    op(0, 1, 2'b10, 0, 0, 32'h20, 0, 0, 2'b01, 5'd2);
    checks++; if (datafrommem !== 32'h80010000) begin errors++; $display("FAIL sh_lanes got=%08h exp=80010000", datafrommem); end
  endtask

  task automatic test_back_to_back();
    // Store and load on the same word in one cycle returns the old contents.
    op(1, 1, 2'b10, 0, 32'h55667788, 32'h10, 0, 0, 2'b01, 5'd4);
    checks++; if (datafrommem !== 32'hAA223344) begin errors++; $display("FAIL read_first got=%08h exp=AA223344", datafrommem); end
    op(0, 1, 2'b10, 0, 0, 32'h10, 0, 0, 2'b01, 5'd4);
    checks++; if (datafrommem !== 32'h55667788) begin errors++; $display("FAIL ld_after_st got=%08h exp=55667788", datafrommem); end
  endtask

  task automatic test_wrap();
    op(1, 0, 2'b10, 0, 32'hCAFEF00D, 32'h1000, 0, 0, 2'b00, 5'd0);
    op(0, 1, 2'b10, 0, 0, 32'h0, 0, 0, 2'b01, 5'd5);
    checks++; if (datafrommem !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap got=%08h exp=CAFEF00D", datafrommem); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_word;
    logic        exp_mis;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    exp_word = 32'h12345678;
    exp_mis  = 1'b1;
`else
    exp_word = 32'hDEADBEEF;
    exp_mis  = 1'b0;
`endif
    op(1, 0, 2'b10, 0, 32'h12345678, 32'h14, 0, 0, 2'b00, 5'd0);
    op(1, 0, 2'b10, 0, 32'hDEADBEEF, 32'h15, 0, 0, 2'b00, 5'd0);
    checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL mis_flag got=%0b exp=%0b", misalign, exp_mis); end
    op(0, 1, 2'b10, 0, 0, 32'h14, 0, 0, 2'b01, 5'd6);
    checks++; if (datafrommem !== exp_word) begin errors++; $display("FAIL mis_word got=%08h exp=%08h", datafrommem, exp_word); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%0b exp=0", misalign); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_we = 1; mem_re = 1; size = 2'b10; data = 32'h99999999; dataaddr = 32'h10;
    wbi = 2'b11; regaddr = 5'd8;
    #2;
    reset = 1;
    #1;
    checks++; if (datafromimm !== 32'h0) begin errors++; $display("FAIL midrst_imm got=%08h exp=0", datafromimm); end
    checks++; if (datafrommem !== 32'h0) begin errors++; $display("FAIL midrst_dout got=%08h exp=0", datafrommem); end
    checks++; if (regaddrout !== 5'd0) begin errors++; $display("FAIL midrst_rd got=%0d exp=0", regaddrout); end
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle_inputs();
    op(0, 1, 2'b10, 0, 0, 32'h10, 0, 0, 2'b01, 5'd8);
    checks++; if (datafrommem !== 32'h55667788) begin errors++; $display("FAIL midrst_keep got=%08h exp=55667788", datafrommem); end
    checks++; if (wbo !== 2'b01) begin errors++; $display("FAIL midrst_wbo got=%0h exp=1", wbo); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width; memory depth 2**ADDR_W words of 32 bits.
REQ-002 Parameter WB_W, default 2: width of the write-back control bundle.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wbi  in  WB_W  write-back control from EX/MEM.
REQ-006 regaddr  in  5  destination register from EX/MEM.
REQ-007 mem_we  in  1  store request.
REQ-008 mem_re  in  1  load request.
REQ-009 size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-010 sign_ext  in  1  1 sign-extends, 0 zero-extends byte/halfword loads.
REQ-011 data  in  32  store data from the register file.
REQ-012 dataaddr  in  32  byte address, also ALU result.
REQ-013 forw  in  1  1 selects result_from_mem as store data.
REQ-014 result_from_mem  in  32  forwarded value from MEM/WB.
REQ-015 wbo  out  WB_W  registered write-back control.
REQ-016 datafrommem  out  32  aligned, extended load data.
REQ-017 datafromimm  out  32  registered ALU result (dataaddr).
REQ-018 regaddrout  out  5  registered destination register.
REQ-019 misalign  out  1  registered misaligned-access flag.

Function
REQ-020 Store data SHALL be result_from_mem when forw=1, else data; selection is combinational.
REQ-021 Word index SHALL be dataaddr[ADDR_W+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*2**ADDR_W.
REQ-022 Byte store SHALL write store_data[7:0] into byte lane dataaddr[1:0] only; the other lanes stay unchanged.
REQ-023 Halfword store SHALL write store_data[15:0] into lanes {1,0} when dataaddr[1]=0, or into lanes {3,2} when dataaddr[1]=1.
REQ-024 Word store SHALL write all four lanes.
REQ-025 Lane 0 SHALL be bits 7:0 (little-endian).
REQ-026 Memory reads SHALL be synchronous: the word addressed in cycle N appears internally after edge N+1.
REQ-027 Read data for a same-cycle store SHALL be the pre-write contents (read-first).
REQ-028 dataaddr[1:0], size, sign_ext and mem_re SHALL be registered alongside the read.
REQ-029 datafrommem SHALL be formed combinationally from the registered read word and registered controls.
REQ-030 datafrommem SHALL be 0 when the registered mem_re is 0.
REQ-031 Load latency SHALL be one cycle: datafrommem, wbo, datafromimm and regaddrout all correspond to the instruction presented one edge earlier.
REQ-032 A load in cycle N+1 from the address stored in cycle N SHALL return the new data.
REQ-033 mem_we=1 and mem_re=1 in the same cycle SHALL perform both the store and a read-first read.

Reset
REQ-034 While reset=1, wbo, datafromimm, regaddrout and misalign SHALL be 0 and datafrommem SHALL read 0, independent of clk.
REQ-035 A store present on an edge while reset=1 SHALL NOT write memory.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 The first edge after reset deasserts SHALL behave as a normal cycle.

Configuration
REQ-038 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: a halfword access with dataaddr[0]=1, or a word access with dataaddr[1:0]!=0, SHALL suppress the memory write.
REQ-039 MEM_STAGE_MISALIGN_TRAP_EN defined: such an access SHALL set misalign=1 for its output cycle and force datafrommem to 0.
REQ-040 MEM_STAGE_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be truncated to the access alignment, the access SHALL proceed, and misalign SHALL be tied to 0.

Verification
REQ-041 sw 0x11223344 @0x10, then lw @0x10 -> datafrommem=0x11223344 one cycle after the load.
REQ-042 sb 0xAA @0x13 over 0x11223344, then lw @0x10 -> 0xAA223344; then lb sign_ext=1 @0x13 -> 0xFFFFFFAA; then lbu -> 0x000000AA.
REQ-043 sh 0x8001 @0x22 with forw=1, result_from_mem=0x00008001, data=0 -> lh @0x22 returns 0xFFFF8001; lhu returns 0x00008001.
REQ-044 With the macro defined, sw 0xDEADBEEF @0x15 -> misalign=1, memory at word 0x14 unchanged; with it undefined -> the word is written at 0x14 and misalign=0.
REQ-045 With ADDR_W=10, sw @0x1000 then lw @0x0000 -> same data (wrap-around).
REQ-046 Assert reset mid-store between edges -> outputs 0 immediately, no write on that edge, and earlier memory data is retained after release.
